mp64_dma_arb: RTL and testbench

Parametrised N-channel DMA arbiter for the Megapad-64 internal memory port B. Disk, NIC and future DMA masters request single memory beats; the block serialises them round-robin, with optional locked bursts, onto one 64-bit memory request interface. Beats issue only while the CPU bus path is idle. An external port-B mux selects DMA traffic while `dma_own` is high.

---
 rtl/mp64_dma_arb.sv | 204 ++++++++++++++++++++
 tb/tb_mp64_dma_arb.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mp64_dma_arb.sv
// Round-robin DMA arbiter for Megapad-64 memory port B.
// Serialises single-beat channel requests, with optional locked bursts, onto one 64-bit memory port.
module mp64_dma_arb #(
  parameter int NCH       = 2,
  parameter int AW        = 20,
  parameter int DW        = 8,
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    ch_req,
  input  logic [NCH-1:0]    ch_lock,
  input  logic [NCH-1:0]    ch_wen,
  input  logic [NCH*AW-1:0] ch_addr,
  input  logic [NCH*DW-1:0] ch_wdata,
  output logic [NCH-1:0]    ch_ack,
  output logic [NCH-1:0]    ch_err,
  output logic [DW-1:0]     ch_rdata,
  input  logic              host_busy,
  output logic              dma_own,
  output logic              mem_en,
  output logic [63:0]       mem_addr,
  output logic [63:0]       mem_wdata,
  output logic              mem_wen,
  output logic [1:0]        mem_size,
  input  logic [63:0]       mem_rdata,
  input  logic              mem_ready
);

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [1:0] SIZE = (DW == 64) ? 2'd3 : (DW == 32) ? 2'd2 : (DW == 16) ? 2'd1 : 2'd0;
  localparam logic [AW-1:0] ALIGN_MASK = AW'(DW / 8 - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, ACK, ERR} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   gnt_q, gnt_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]   burst_cnt_q, burst_cnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            wen_q, wen_d;
  logic [1:0]      size_q, size_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [NCH-1:0]  ack_q, ack_d;
  logic [NCH-1:0]  err_q, err_d;
  logic            en_q, en_d;
  logic            own_q, own_d;

  logic            found;
  int              win_i;
  logic [AW-1:0]   win_addr, cur_addr;
  logic [DW-1:0]   win_wdata, cur_wdata;
  logic            win_wen, cur_wen, cur_req, cur_lock;
  logic [IW-1:0]   next_ptr;
  logic            unused_rdata;

  assign unused_rdata = ^mem_rdata;

  function automatic logic misaligned(input logic [AW-1:0] a);
    return |(a & ALIGN_MASK);
  endfunction

  // Rotating priority search starting at rr_ptr, plus field muxes for the winner and the current grant.
  always_comb begin
    found     = 1'b0;
    win_i     = 0;
    win_addr  = '0;
    win_wdata = '0;
    win_wen   = 1'b0;
    cur_addr  = '0;
    cur_wdata = '0;
    cur_wen   = 1'b0;
    cur_req   = 1'b0;
    cur_lock  = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      for (int i = 0; i < NCH; i++) begin
        if (!found && ch_req[i] && (((int'(rr_ptr_q) + k) % NCH) == i)) begin
          found = 1'b1;
          win_i = i;
        end
      end
    end
    for (int i = 0; i < NCH; i++) begin
      if (win_i == i) begin
        win_addr  = ch_addr[i*AW +: AW];
        win_wdata = ch_wdata[i*DW +: DW];
        win_wen   = ch_wen[i];
      end
      if (int'(gnt_q) == i) begin
        cur_addr  = ch_addr[i*AW +: AW];
        cur_wdata = ch_wdata[i*DW +: DW];
        cur_wen   = ch_wen[i];
        cur_req   = ch_req[i];
        cur_lock  = ch_lock[i];
      end
    end
    next_ptr = IW'((int'(gnt_q) + 1) % NCH);
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wen_d       = wen_q;
    size_d      = size_q;
    rdata_d     = rdata_q;
    ack_d       = '0;
    err_d       = '0;
    case (state_q)
      IDLE: begin
        if (found && !host_busy) begin
          gnt_d   = IW'(win_i);
          addr_d  = win_addr;
          wdata_d = win_wdata;
          wen_d   = win_wen;
          size_d  = SIZE;
          if (misaligned(win_addr)) begin
            state_d = ERR;
            err_d   = NCH'(1) << win_i;
          end else begin
            state_d     = ISSUE;
            burst_cnt_d = '0;
          end
        end
      end
      ISSUE: begin
        if (mem_ready) begin
          rdata_d     = mem_rdata[DW-1:0];
          burst_cnt_d = burst_cnt_q + CW'(1);
          ack_d       = NCH'(1) << gnt_q;
          state_d     = ACK;
        end
      end
      ACK: begin
        // A locked burst keeps the grant without re-arbitration until the beat cap forces rotation.
        if (cur_lock && cur_req && (burst_cnt_q < CW'(MAX_BURST)) &&
            !misaligned(cur_addr) && !host_busy) begin
          addr_d  = cur_addr;
          wdata_d = cur_wdata;
          wen_d   = cur_wen;
          state_d = ISSUE;
        end else begin
          rr_ptr_d = next_ptr;
          state_d  = IDLE;
        end
      end
      ERR: begin
        rr_ptr_d = next_ptr;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    en_d  = (state_d == ISSUE);
    own_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wen_q       <= 1'b0;
      size_q      <= 2'd0;
      rdata_q     <= '0;
      ack_q       <= '0;
      err_q       <= '0;
      en_q        <= 1'b0;
      own_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wen_q       <= wen_d;
      size_q      <= size_d;
      rdata_q     <= rdata_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      en_q        <= en_d;
      own_q       <= own_d;
    end
  end

  assign ch_ack    = ack_q;
  assign ch_err    = err_q;
  assign ch_rdata  = rdata_q;
  assign dma_own   = own_q;
  assign mem_en    = en_q;
  assign mem_addr  = 64'(addr_q);
  assign mem_wdata = 64'(wdata_q);
  assign mem_wen   = wen_q;
  assign mem_size  = size_q;

endmodule

// File: tb/tb_mp64_dma_arb.sv
// Directed bench for mp64_dma_arb: an 8-bit instance with a 4-beat cap and a 32-bit instance.
module tb_mp64_dma_arb;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  logic [1:0]  req_a, lock_a, wen_a, ack_a, err_a;
  logic [39:0] addr_a;
  logic [15:0] wdata_a;
  logic [7:0]  rdata_a;
  logic        busy_a, own_a, en_a, mwen_a, mready_a;
  logic [63:0] maddr_a, mwdata_a, mrdata_a;
  logic [1:0]  msize_a;

  logic [1:0]  req_b, lock_b, wen_b, ack_b, err_b;
  logic [39:0] addr_b;
  logic [63:0] wdata_b;
  logic [31:0] rdata_b;
  logic        busy_b, own_b, en_b, mwen_b, mready_b;
  logic [63:0] maddr_b, mwdata_b, mrdata_b;
  logic [1:0]  msize_b;

  mp64_dma_arb #(.NCH(2), .AW(20), .DW(8), .MAX_BURST(4)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .ch_req(req_a), .ch_lock(lock_a), .ch_wen(wen_a), .ch_addr(addr_a), .ch_wdata(wdata_a),
    .ch_ack(ack_a), .ch_err(err_a), .ch_rdata(rdata_a),
    .host_busy(busy_a), .dma_own(own_a),
    .mem_en(en_a), .mem_addr(maddr_a), .mem_wdata(mwdata_a), .mem_wen(mwen_a),
    .mem_size(msize_a), .mem_rdata(mrdata_a), .mem_ready(mready_a)
  );

  mp64_dma_arb #(.NCH(2), .AW(20), .DW(32), .MAX_BURST(16)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .ch_req(req_b), .ch_lock(lock_b), .ch_wen(wen_b), .ch_addr(addr_b), .ch_wdata(wdata_b),
    .ch_ack(ack_b), .ch_err(err_b), .ch_rdata(rdata_b),
    .host_busy(busy_b), .dma_own(own_b),
    .mem_en(en_b), .mem_addr(maddr_b), .mem_wdata(mwdata_b), .mem_wen(mwen_b),
    .mem_size(msize_b), .mem_rdata(mrdata_b), .mem_ready(mready_b)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Moves to 1 time unit past the next rising edge; inputs set afterwards apply to that cycle.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetState();
    checkOutput("rst_ack_a", 64'(ack_a), 0);
    checkOutput("rst_err_a", 64'(err_a), 0);
    checkOutput("rst_rdata_a", 64'(rdata_a), 0);
    checkOutput("rst_own_a", 64'(own_a), 0);
    checkOutput("rst_en_a", 64'(en_a), 0);
    checkOutput("rst_maddr_a", maddr_a, 0);
    checkOutput("rst_mwdata_a", mwdata_a, 0);
    checkOutput("rst_mwen_a", 64'(mwen_a), 0);
    checkOutput("rst_ack_b", 64'(ack_b), 0);
    checkOutput("rst_rdata_b", 64'(rdata_b), 0);
    checkOutput("rst_own_b", 64'(own_b), 0);
    checkOutput("rst_en_b", 64'(en_b), 0);
    checkOutput("rst_maddr_b", maddr_b, 0);
    checkOutput("rst_msize_b", 64'(msize_b), 0);
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    {req_a, lock_a, wen_a, addr_a, wdata_a, busy_a, mrdata_a, mready_a} = '0;
    {req_b, lock_b, wen_b, addr_b, wdata_b, busy_b, mrdata_b, mready_b} = '0;
    applyStimulus();
    applyStimulus();
    checkResetState();
    rst_n = 1'b1;
  endtask

  initial begin
    int beats;
    int n_ack0;
    logic [1:0] exp_ack;
    logic exp_en;

    // Single write on the 8-bit instance.
    resetDut();
    wen_a = 2'b01; addr_a = {20'h00456, 20'h00123}; wdata_a = 16'h00A5; mready_a = 1'b1; req_a = 2'b01;
    applyStimulus();
    checkOutput("wr_en", 64'(en_a), 1);
    checkOutput("wr_addr", maddr_a, 64'h123);
    checkOutput("wr_wdata", mwdata_a, 64'hA5);
    checkOutput("wr_wen", 64'(mwen_a), 1);
    checkOutput("wr_size", 64'(msize_a), 0);
    checkOutput("wr_own", 64'(own_a), 1);
    checkOutput("wr_ack_c1", 64'(ack_a), 0);
    applyStimulus();
    checkOutput("wr_ack_c2", 64'(ack_a), 2'b01);
    checkOutput("wr_en_c2", 64'(en_a), 0);
    req_a = 2'b00;
    applyStimulus();
    checkOutput("wr_ack_c3", 64'(ack_a), 0);
    checkOutput("wr_own_c3", 64'(own_a), 0);

    // Fairness: both channels request continuously, no lock.
    resetDut();
    addr_a = {20'h00456, 20'h00123}; mready_a = 1'b1; req_a = 2'b11;
    beats = 0;
    for (int c = 1; c <= 40 && beats < 8; c++) begin
      applyStimulus();
      if (ack_a != 2'b00) begin
        checkOutput($sformatf("fair_gnt%0d", beats), 64'(ack_a), (beats % 2 == 0) ? 64'd1 : 64'd2);
        checkOutput($sformatf("fair_cyc%0d", beats), 64'(c), 64'(2 + 3 * beats));
        beats++;
        if (beats == 8) req_a = 2'b00;
      end
    end
    checkOutput("fair_beats", 64'(beats), 8);
    applyStimulus();
    req_a = 2'b11;
    applyStimulus();
    checkOutput("fair_ptr_en", 64'(en_a), 1);
    checkOutput("fair_ptr_addr", maddr_a, 64'h123);
    applyStimulus();
    checkOutput("fair_ptr_ack", 64'(ack_a), 2'b01);

    // Burst cap of 4: ch0 locked for 6 beats, ch1 wants one beat.
    resetDut();
    addr_a = {20'h00456, 20'h00123}; mready_a = 1'b1; req_a = 2'b11; lock_a = 2'b01;
    n_ack0 = 0;
    for (int c = 1; c <= 18; c++) begin
      applyStimulus();
      exp_ack = 2'b00;
      exp_en  = 1'b0;
      case (c)
        2, 4, 6, 8, 14, 16: exp_ack = 2'b01;
        11:                 exp_ack = 2'b10;
        default:            exp_ack = 2'b00;
      endcase
      case (c)
        1, 3, 5, 7, 10, 13, 15: exp_en = 1'b1;
        default:                exp_en = 1'b0;
      endcase
      checkOutput($sformatf("burst_ack_c%0d", c), 64'(ack_a), 64'(exp_ack));
      checkOutput($sformatf("burst_en_c%0d", c), 64'(en_a), 64'(exp_en));
      if (ack_a[0]) begin
        n_ack0++;
        if (n_ack0 == 6) req_a[0] = 1'b0;
      end
      if (ack_a[1]) req_a[1] = 1'b0;
    end

    // Host priority: port B busy for cycles 0-5, ch1 waiting.
    resetDut();
    addr_a = {20'h00456, 20'h00123}; mready_a = 1'b1; req_a = 2'b10; busy_a = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      applyStimulus();
      if (c <= 7) begin
        checkOutput($sformatf("host_en_c%0d", c), 64'(en_a), 64'(c == 7));
        checkOutput($sformatf("host_own_c%0d", c), 64'(own_a), 64'(c == 7));
      end
      if (c == 7) checkOutput("host_addr", maddr_a, 64'h456);
      if (c == 8) begin
        checkOutput("host_ack", 64'(ack_a), 2'b10);
        req_a = 2'b00;
      end
      busy_a = (c <= 5);
    end

    // 32-bit instance: misaligned read, then aligned read with three wait cycles.
    resetDut();
    addr_b = {20'h0, 20'h00006}; wen_b = 2'b00; req_b = 2'b01;
    applyStimulus();
    checkOutput("err_pulse", 64'(err_b), 2'b01);
    checkOutput("err_en", 64'(en_b), 0);
    checkOutput("err_own", 64'(own_b), 1);
    req_b = 2'b00;
    applyStimulus();
    checkOutput("err_clear", 64'(err_b), 0);
    checkOutput("err_en_c2", 64'(en_b), 0);
    checkOutput("err_own_c2", 64'(own_b), 0);
    addr_b = {20'h0, 20'h00008}; wdata_b = 64'h0000_0000_1234_5678;
    mrdata_b = 64'h1111_2222_3333_4444; mready_b = 1'b0; req_b = 2'b01;
    for (int c = 1; c <= 6; c++) begin
      applyStimulus();
      checkOutput($sformatf("rd_en_c%0d", c), 64'(en_b), 64'(c <= 4));
      checkOutput($sformatf("rd_ack_c%0d", c), 64'(ack_b), (c == 5) ? 64'd1 : 64'd0);
      if (c == 1) begin
        checkOutput("rd_size", 64'(msize_b), 2);
        checkOutput("rd_addr", maddr_b, 64'h8);
        checkOutput("rd_wdata", mwdata_b, 64'h1234_5678);
        checkOutput("rd_wen", 64'(mwen_b), 0);
      end
      if (c >= 5) checkOutput($sformatf("rd_data_c%0d", c), 64'(rdata_b), 64'hDEAD_BEEF);
      mready_b = (c == 4);
      mrdata_b = (c == 4) ? 64'h0000_0000_DEAD_BEEF : 64'h5555_6666_7777_8888;
      if (ack_b[0]) req_b = 2'b00;
    end

    // Asynchronous reset in the middle of a beat that memory never completes.
    resetDut();
    addr_a = {20'h00456, 20'h00100}; mready_a = 1'b0; req_a = 2'b01;
    applyStimulus();
    checkOutput("mid_en_before", 64'(en_a), 1);
    checkOutput("mid_own_before", 64'(own_a), 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_en_async", 64'(en_a), 0);
    checkOutput("mid_own_async", 64'(own_a), 0);
    checkOutput("mid_ack_async", 64'(ack_a), 0);
    checkOutput("mid_addr_async", maddr_a, 0);
    mready_a = 1'b1;
    applyStimulus();
    checkOutput("mid_ack_held", 64'(ack_a), 0);
    applyStimulus();
    rst_n = 1'b1;
    req_a = 2'b11;
    applyStimulus();
    checkOutput("mid_post_en", 64'(en_a), 1);
    checkOutput("mid_post_addr", maddr_a, 64'h100);
    applyStimulus();
    checkOutput("mid_post_ack", 64'(ack_a), 2'b01);
    req_a = 2'b00;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
